// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE, one EXEC cycle to capture the ALU result,
// then RESP holds the registered result until the granted requester accepts.
// The last completed result is also kept for the seven-segment display path.
module alu_share_ctrl #(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_b0,
  input  logic [OPW-1:0] req_op0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b1,
  input  logic [OPW-1:0] req_op1,
  output logic [1:0]     resp_valid,
  input  logic [1:0]     resp_ready,
  output logic [W-1:0]   resp_data,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  output logic           busy,
  output logic [W-1:0]   disp_val,
  output logic           disp_src,
  output logic [7:0]     txn_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_rr;
  logic           r_gnt;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [OPW-1:0] r_op;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_disp_val;
  logic           r_disp_src;
  logic [7:0]     r_txn_count;

  logic           w_gnt;
  logic           w_accept;
  logic           w_resp_hs;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [OPW-1:0] w_sel_op;

  // Winner selection: a lone requester wins outright, a tie goes to the rr pointer
  always_comb begin
    w_gnt = 1'b0;
    unique case (req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = r_rr;
      default: w_gnt = 1'b0;
    endcase
  end

  // Operand mux for the current winner
  always_comb begin
    w_sel_a  = w_gnt ? req_a1  : req_a0;
    w_sel_b  = w_gnt ? req_b1  : req_b0;
    w_sel_op = w_gnt ? req_op1 : req_op0;
  end

  // Next-state and handshake outputs; rst gates the handshakes so they drop asynchronously
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    w_accept    = 1'b0;
    w_resp_hs   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!rst && req_valid[w_gnt]) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!rst) begin
          resp_valid[r_gnt] = 1'b1;
        end
        if (resp_ready[r_gnt]) begin
          w_resp_hs   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transaction datapath: operand capture, result capture, pointer and counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr        <= 1'b0;
      r_gnt       <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_op        <= '0;
      r_res       <= '0;
      r_disp_val  <= '0;
      r_disp_src  <= 1'b0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        r_opa <= w_sel_a;
        r_opb <= w_sel_b;
        r_op  <= w_sel_op;
        r_gnt <= w_gnt;
      end
      if (r_state == S_EXEC) begin
        r_res      <= alu_out;
        r_disp_val <= alu_out;
        r_disp_src <= r_gnt;
      end
      if (w_resp_hs) begin
        r_rr        <= ~r_gnt;
        r_txn_count <= r_txn_count + 8'd1;
      end
    end
  end

  assign alu_a     = r_opa;
  assign alu_b     = r_opb;
  assign alu_op    = r_op;
  assign resp_data = r_res;
  assign busy      = (r_state != S_IDLE);
  assign disp_val  = r_disp_val;
  assign disp_src  = r_disp_src;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic.
// Expected responses are queued by the stimulus side; a negedge monitor pops
// and compares them whenever the DUT presents a response.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0] req_op0, req_op1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [3:0] resp_data;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       busy;
  logic [3:0] disp_val;
  logic       disp_src;
  logic [7:0] txn_count;

  alu_share_ctrl #(.W(4), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .busy(busy), .disp_val(disp_val), .disp_src(disp_src), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // 8-op ALU: add, sub, and, or, xor, not a, a<<1, a>>1
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_op);

  typedef struct {
    logic       src;
    logic [3:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned m_done = 0;
  logic [7:0]  m_cnt = '0;
  logic        m_rr = 1'b0;
  int          n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented response against the queue head
  always @(negedge clk) begin
    if (!rst && resp_valid != 2'b00) begin
      if (q.size() == 0) begin
        chk("resp_unexpected", {30'd0, resp_valid}, 32'd0);
      end else begin
        chk("resp_valid", {30'd0, resp_valid}, (q[0].src ? 32'd2 : 32'd1));
        chk("resp_data", {28'd0, resp_data}, {28'd0, q[0].data});
        chk("busy_resp", {31'd0, busy}, 32'd1);
        chk("req_ready_resp", {30'd0, req_ready}, 32'd0);
        chk("disp_val", {28'd0, disp_val}, {28'd0, q[0].data});
        chk("disp_src", {31'd0, disp_src}, {31'd0, q[0].src});
        chk("txn_count_resp", {24'd0, txn_count}, {24'd0, m_cnt});
        if (resp_ready[q[0].src]) begin
          void'(q.pop_front());
          m_cnt = m_cnt + 8'd1;
          m_done++;
        end
      end
    end
  end

  task automatic wait_done(input int unsigned target, input int budget);
    int k = 0;
    while (m_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (m_done < target) chk("timeout", 32'd0, 32'd1);
  endtask

  // One transaction from IDLE; wrong=1 stalls with only the other side's ready
  task automatic do_txn(input logic [1:0] mask,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                        input int stall, input logic wrong);
    logic        w;
    exp_t        e;
    int unsigned start;
    @(posedge clk); #1;
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
    req_valid = mask;
    w = (mask == 2'b11) ? m_rr : mask[1];
    e.src  = w;
    e.data = w ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
    q.push_back(e);
    start = m_done;
    @(negedge clk);
    chk("req_ready_grant", {30'd0, req_ready}, (w ? 32'd2 : 32'd1));
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int s = 0; s < stall; s++) begin
      resp_ready = wrong ? (w ? 2'b01 : 2'b10) : 2'b00;
      req_valid  = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    req_valid  = 2'b00;
    resp_ready = (w ? 2'b10 : 2'b01) | (w ? 2'b00 : 2'($urandom_range(0, 1) << 1))
                 | (w ? 2'($urandom_range(0, 1)) : 2'b00);
    if (stall >= 1) begin
      @(posedge clk);
      chk("complete_first_ready", m_done - start, 32'd1);
    end
    wait_done(start + 1, 40);
    #1;
    resp_ready = 2'b00;
    m_rr = ~w;
    n_txn++;
    chk("txn_count_after", {24'd0, txn_count}, {24'd0, m_cnt});
    if (n_txn == 256) chk("txn_wrap", {24'd0, txn_count}, 32'd0);
  endtask

  initial begin
    int unsigned start;
    rst = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txn_count", {24'd0, txn_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 0: 3 + 4 with add
    @(posedge clk); #1;
    req_a0 = 4'd3; req_b0 = 4'd4; req_op0 = 3'd0; req_valid = 2'b01;
    q.push_back('{src: 1'b0, data: 4'd7});
    start = m_done;
    @(negedge clk);
    chk("single_req_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00; resp_ready = 2'b01;
    @(negedge clk);
    chk("single_alu_a", {28'd0, alu_a}, 32'd3);
    chk("single_alu_b", {28'd0, alu_b}, 32'd4);
    chk("single_exec_busy", {31'd0, busy}, 32'd1);
    chk("single_exec_resp_valid", {30'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("single_resp_valid", {30'd0, resp_valid}, 32'd1);
    chk("single_resp_data", {28'd0, resp_data}, 32'd7);
    wait_done(start + 1, 10);
    #1;
    resp_ready = 2'b00;
    m_rr = 1'b1;
    chk("single_txn_count", {24'd0, txn_count}, 32'd1);
    chk("single_disp_val", {28'd0, disp_val}, 32'd7);
    chk("single_disp_src", {31'd0, disp_src}, 32'd0);
    chk("single_idle_resp_valid", {30'd0, resp_valid}, 32'd0);

    // Reset asserted mid-EXEC
    @(posedge clk); #1;
    req_a1 = 4'd9; req_b1 = 4'd5; req_op1 = 3'd3; req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("arst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_alu", {21'd0, alu_a, alu_b, alu_op}, 32'd0);
    chk("arst_disp", {27'd0, disp_val, disp_src}, 32'd0);
    chk("arst_txn_count", {24'd0, txn_count}, 32'd0);
    chk("arst_resp_data", {28'd0, resp_data}, 32'd0);
    req_valid = 2'b00;
    q.delete();
    m_cnt = '0; m_rr = 1'b0; n_txn = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", {30'd0, resp_valid}, 32'd0);
      chk("post_rst_txn_count", {24'd0, txn_count}, 32'd0);
    end

    // Both requesters valid throughout: served 0, 1, 0
    @(posedge clk); #1;
    req_a0 = 4'd2; req_b0 = 4'd5; req_op0 = 3'd1;
    req_a1 = 4'd6; req_b1 = 4'd3; req_op1 = 3'd2;
    req_valid = 2'b11; resp_ready = 2'b11;
    q.push_back('{src: 1'b0, data: 4'd13});
    q.push_back('{src: 1'b1, data: 4'd2});
    q.push_back('{src: 1'b0, data: 4'd13});
    start = m_done;
    wait_done(start + 3, 40);
    #1;
    req_valid = 2'b00; resp_ready = 2'b00;
    m_rr = 1'b1; n_txn = 3;
    chk("rr_txn_count", {24'd0, txn_count}, 32'd3);
    chk("rr_disp_src_last", {31'd0, disp_src}, 32'd0);

    // Backpressure on requester 0, then wrong-side ready while requester 1 is granted
    do_txn(2'b01, 4'd11, 4'd6, 3'd4, 4'd0, 4'd0, 3'd0, 6, 1'b0);
    do_txn(2'b10, 4'd0, 4'd0, 3'd0, 4'd12, 4'd3, 3'd6, 6, 1'b1);

    // Random traffic through the 256-transaction wrap
    while (n_txn < 262) begin
      do_txn(2'($urandom_range(1, 3)),
             4'($urandom), 4'($urandom), 3'($urandom),
             4'($urandom), 4'($urandom), 3'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
